// File: rtl/input_fifo.sv
// Spike-event FIFO pairing a binary-time stamp with a neuron ID.
// Sits between the spike source and the scheduler, which watches BT_Head.
module input_fifo #(
  parameter int BT_WIDTH     = 36,
  parameter int FIFO_WIDTH   = 11,
  parameter int NEURON_WIDTH = 11
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    QueueEnable,
  input  logic                    Dequeue,
  input  logic                    Enqueue,
  input  logic [BT_WIDTH-1:0]     BTIn,
  input  logic [NEURON_WIDTH-1:0] NIDIn,
  output logic [BT_WIDTH-1:0]     BTOut,
  output logic [NEURON_WIDTH-1:0] NIDOut,
  output logic [BT_WIDTH-1:0]     BT_Head,
  output logic                    IsQueueEmpty,
  output logic                    IsQueueFull
);

  localparam int DEPTH = 1 << FIFO_WIDTH;
  localparam logic [FIFO_WIDTH:0] FULL_CNT = (FIFO_WIDTH+1)'(DEPTH);

  logic [BT_WIDTH-1:0]     FIFO_BT  [DEPTH];
  logic [NEURON_WIDTH-1:0] FIFO_NID [DEPTH];

  logic [FIFO_WIDTH-1:0]   head_q, head_d;
  logic [FIFO_WIDTH-1:0]   tail_q, tail_d;
  logic [FIFO_WIDTH:0]     count_q, count_d;
  logic [BT_WIDTH-1:0]     bt_out_q, bt_out_d;
  logic [NEURON_WIDTH-1:0] nid_out_q, nid_out_d;

  logic do_push;
  logic do_pop;

  assign IsQueueEmpty = (count_q == '0);
  assign IsQueueFull  = (count_q == FULL_CNT);

  assign do_pop  = QueueEnable && Dequeue && !IsQueueEmpty;
  // At full, a concurrent pop frees the slot the push reuses.
  assign do_push = QueueEnable && Enqueue && (!IsQueueFull || do_pop);

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    bt_out_d  = bt_out_q;
    nid_out_d = nid_out_q;
    if (do_pop) begin
      bt_out_d  = FIFO_BT[head_q];
      nid_out_d = FIFO_NID[head_q];
      head_d    = head_q + 1'b1;
    end
    if (do_push) begin
      tail_d = tail_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      bt_out_q  <= '0;
      nid_out_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      bt_out_q  <= bt_out_d;
      nid_out_q <= nid_out_d;
    end
  end

  // Storage is never cleared by reset.
  always_ff @(posedge Clock) begin
    if (do_push) begin
      FIFO_BT[tail_q]  <= BTIn;
      FIFO_NID[tail_q] <= NIDIn;
    end
  end

  assign BTOut   = bt_out_q;
  assign NIDOut  = nid_out_q;
  assign BT_Head = IsQueueEmpty ? '0 : FIFO_BT[head_q];

endmodule

// File: tb/tb_input_fifo.sv
// Directed scoreboard bench for input_fifo.
// Expected pops come from a queue filled as pushes are driven.
module tb_input_fifo;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        QueueEnable = 1'b1;
  logic        Dequeue = 1'b0;
  logic        Enqueue = 1'b0;
  logic [35:0] BTIn = '0;
  logic [10:0] NIDIn = '0;
  logic [35:0] BTOut;
  logic [10:0] NIDOut;
  logic [35:0] BT_Head;
  logic        IsQueueEmpty;
  logic        IsQueueFull;

  int checks = 0;
  int errors = 0;

  logic [46:0] sb[$];
  logic [46:0] e;
  int          mcount;
  int          wptr;
  logic [35:0] last_bt;
  logic [10:0] last_nid;

  input_fifo dut (
    .Clock(Clock), .Reset(Reset), .QueueEnable(QueueEnable),
    .Dequeue(Dequeue), .Enqueue(Enqueue),
    .BTIn(BTIn), .NIDIn(NIDIn),
    .BTOut(BTOut), .NIDOut(NIDOut), .BT_Head(BT_Head),
    .IsQueueEmpty(IsQueueEmpty), .IsQueueFull(IsQueueFull)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic enq, input logic deq,
                      input logic [35:0] bt, input logic [10:0] nid);
    Enqueue = enq;
    Dequeue = deq;
    BTIn    = bt;
    NIDIn   = nid;
    @(posedge Clock);
    #1;
    Enqueue = 1'b0;
    Dequeue = 1'b0;
  endtask

  function automatic logic [35:0] mkbt(input int v);
    return (36'(v) << 4) | 36'h8;
  endfunction

  task automatic push(input int v);
    logic [35:0] b;
    b = mkbt(v);
    tick(1'b1, 1'b0, b, 11'(v));
    sb.push_back({b, 11'(v)});
    mcount++;
    wptr = (wptr + 1) % 2048;
  endtask

  task automatic pop_chk(input string tag);
    tick(1'b0, 1'b1, '0, '0);
    e = sb.pop_front();
    mcount--;
    last_bt  = e[46:11];
    last_nid = e[10:0];
    chk({tag, "_bt"}, 64'(BTOut), 64'(last_bt));
    chk({tag, "_nid"}, 64'(NIDOut), 64'(last_nid));
  endtask

  initial begin
    mcount = 0;
    wptr   = 0;
    #15;
    chk("rst_btout", 64'(BTOut), 64'h0);
    chk("rst_nidout", 64'(NIDOut), 64'h0);
    chk("rst_empty", 64'(IsQueueEmpty), 64'h1);
    chk("rst_full", 64'(IsQueueFull), 64'h0);
    chk("rst_head", 64'(BT_Head), 64'h0);
    Reset = 1'b1;
    @(posedge Clock);
    #1;

    for (int k = 0; k < 2048; k++) push(k);
    chk("fill_full", 64'(IsQueueFull), 64'h1);
    chk("fill_head", 64'(BT_Head), 64'h8);
    chk("fill_cnt", 64'(dut.count_q), 64'(mcount));

    tick(1'b1, 1'b0, 36'hABCDE, 11'h155);
    chk("xpush_mem", 64'(dut.FIFO_BT[0]), 64'h8);
    chk("xpush_nid", 64'(dut.FIFO_NID[0]), 64'h0);
    chk("xpush_full", 64'(IsQueueFull), 64'h1);
    chk("xpush_cnt", 64'(dut.count_q), 64'(mcount));

    for (int k = 0; k < 2048; k++) pop_chk("drain");
    chk("drain_empty", 64'(IsQueueEmpty), 64'h1);
    chk("drain_head", 64'(BT_Head), 64'h0);
    tick(1'b0, 1'b1, '0, '0);
    chk("xpop_bt", 64'(BTOut), 64'(mkbt(2047)));
    chk("xpop_nid", 64'(NIDOut), 64'd2047);
    chk("xpop_empty", 64'(IsQueueEmpty), 64'h1);

    for (int i = 0; i < 20; i++) begin
      push(i + 17);
      chk("il_mem", 64'(dut.FIFO_BT[i]), 64'(mkbt(i + 17)));
      pop_chk("il_pop");
    end

    tick(1'b1, 1'b1, mkbt(500), 11'd500);
    sb.push_back({mkbt(500), 11'd500});
    mcount++;
    wptr = (wptr + 1) % 2048;
    chk("se_cnt", 64'(dut.count_q), 64'd1);
    chk("se_hold", 64'(BTOut), 64'(last_bt));
    chk("se_head", 64'(BT_Head), 64'(mkbt(500)));

    for (int k = 0; k < 2047; k++) push(1000 + k);
    chk("sf_full0", 64'(IsQueueFull), 64'h1);
    begin
      int idx;
      idx = wptr;
      tick(1'b1, 1'b1, mkbt(77), 11'd77);
      e = sb.pop_front();
      sb.push_back({mkbt(77), 11'd77});
      wptr = (wptr + 1) % 2048;
      last_bt  = e[46:11];
      last_nid = e[10:0];
      chk("sf_cnt", 64'(dut.count_q), 64'd2048);
      chk("sf_full", 64'(IsQueueFull), 64'h1);
      chk("sf_bt", 64'(BTOut), 64'(last_bt));
      chk("sf_nid", 64'(NIDOut), 64'(last_nid));
      chk("sf_mem", 64'(dut.FIFO_BT[idx]), 64'(mkbt(77)));
      chk("sf_head", 64'(BT_Head), 64'(sb[0][46:11]));
    end

    QueueEnable = 1'b0;
    for (int c = 0; c < 5; c++) tick(1'b1, 1'b1, 36'h123, 11'h7);
    chk("qe_full", 64'(IsQueueFull), 64'h1);
    chk("qe_empty", 64'(IsQueueEmpty), 64'h0);
    chk("qe_bt", 64'(BTOut), 64'(last_bt));
    chk("qe_nid", 64'(NIDOut), 64'(last_nid));
    chk("qe_head", 64'(BT_Head), 64'(sb[0][46:11]));
    chk("qe_mem", 64'(dut.FIFO_BT[wptr]), 64'(sb[0][46:11]));
    QueueEnable = 1'b1;
    pop_chk("qe_pop");

    Reset = 1'b0;
    #2;
    Reset = 1'b1;
    sb.delete();
    mcount = 0;
    wptr = 0;
    @(posedge Clock);
    #1;
    for (int k = 0; k < 10; k++) push(300 + k);
    chk("mr_cnt", 64'(dut.count_q), 64'd10);
    #2;
    Reset = 1'b0;
    #1;
    chk("mr_empty", 64'(IsQueueEmpty), 64'h1);
    chk("mr_bt", 64'(BTOut), 64'h0);
    Reset = 1'b1;
    sb.delete();
    mcount = 0;
    wptr = 0;
    @(posedge Clock);
    #1;
    push(900);
    chk("mr_mem0", 64'(dut.FIFO_BT[0]), 64'(mkbt(900)));
    chk("mr_head", 64'(BT_Head), 64'(mkbt(900)));
    pop_chk("mr_pop");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
